// File: rtl/mem_arbiter.sv
// Unified program/data memory arbiter for fetch and load/store.
// Grants one requester per cycle, returns data one cycle later.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int REG_BIT  = 14,
  parameter int PROG_BIT = 13,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  input  logic              prog_we_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              reg_write,
  output logic [14:0]       reg_addr,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata,
  output logic              prog_writing
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_q, wait_d;
  logic          vld_q, vld_d;
  logic          own_q, own_d;
  logic          src_q, src_d;
  logic          err_q, err_d;
  logic          st_q, st_d;
  logic [31:0]   rdat_q, rdat_d;

  logic fetch_force;
  logic d_reg, d_blk, if_reg;
  logic d_mem, i_mem;

  assign fetch_force = if_req && (wait_q == CW'(MAX_WAIT));
  assign d_reg  = d_addr[REG_BIT];
  assign if_reg = if_addr[REG_BIT];
  assign d_blk  = d_we && !d_addr[PROG_BIT] && !prog_we_en;

  // Grant decision: data first unless fetch has starved too long
  always_comb begin
    d_gnt  = !reset && d_req && !fetch_force;
    if_gnt = !reset && if_req && (!d_req || fetch_force);
    d_mem  = d_gnt && !d_reg && !d_blk;
    i_mem  = if_gnt && !if_reg;
  end

  // Memory and register-window port drive for the granted access
  always_comb begin
    mem_req      = d_mem || i_mem;
    mem_we       = d_mem && d_we;
    mem_funct3   = '0;
    mem_addr     = '0;
    if (d_mem) begin
      mem_funct3 = d_funct3;
      mem_addr   = d_addr;
    end else if (i_mem) begin
      mem_funct3 = 3'b010;
      mem_addr   = if_addr;
    end
    mem_wdata    = mem_we ? d_wdata : '0;
    prog_writing = mem_req && mem_we && !mem_addr[PROG_BIT];
    reg_write    = d_gnt && d_reg && d_we;
    reg_addr     = (d_gnt && d_reg) ? d_addr[14:0] : '0;
    reg_wdata    = reg_write ? d_wdata : '0;
  end

  // Starvation counter and response tag next state
  always_comb begin
    wait_d = '0;
    if (if_req && !if_gnt)
      wait_d = (wait_q == CW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
    vld_d  = if_gnt || d_gnt;
    own_d  = d_gnt;
    src_d  = d_gnt ? d_reg : if_reg;
    err_d  = d_gnt ? (!d_reg && d_blk) : if_reg;
    st_d   = d_gnt && d_we;
    rdat_d = (d_gnt && d_reg && !d_we) ? reg_rdata : rdat_q;
  end

  // State registers; reset drops any pending response
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
      vld_q  <= 1'b0;
      own_q  <= 1'b0;
      src_q  <= 1'b0;
      err_q  <= 1'b0;
      st_q   <= 1'b0;
      rdat_q <= '0;
    end else begin
      wait_q <= wait_d;
      vld_q  <= vld_d;
      own_q  <= own_d;
      src_q  <= src_d;
      err_q  <= err_d;
      st_q   <= st_d;
      rdat_q <= rdat_d;
    end
  end

  // Response steering to the tagged owner
  always_comb begin
    if_rvalid = !reset && vld_q && !own_q && !if_flush;
    if_err    = if_rvalid && err_q;
    if_rdata  = (if_rvalid && !err_q) ? mem_rdata : '0;
    d_rvalid  = !reset && vld_q && own_q;
    d_err     = d_rvalid && err_q;
    d_rdata   = '0;
    if (d_rvalid && !st_q)
      d_rdata = src_q ? rdat_q : mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter.
// One table row per clock cycle: inputs plus expected outputs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_funct3 = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        prog_we_en = 1'b0;
  logic        mem_req, mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        reg_write;
  logic [14:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata = '0;
  logic        prog_writing;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(32), .REG_BIT(14), .PROG_BIT(13), .MAX_WAIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .prog_we_en(prog_we_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .reg_write(reg_write), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .prog_writing(prog_writing)
  );

  typedef struct packed {
    logic        rst;
    logic        ifr;
    logic [31:0] ia;
    logic        fl;
    logic        dr;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] da;
    logic [31:0] wd;
    logic        pe;
    logic [31:0] mr;
    logic [31:0] rr;
    logic        ig;
    logic        iv;
    logic [31:0] ird;
    logic        ie;
    logic        dg;
    logic        dv;
    logic [31:0] drd;
    logic        de;
    logic        mq;
    logic        mw;
    logic [2:0]  mf;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic        pw;
    logic        rw;
    logic [14:0] ra;
    logic [31:0] rwd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h expected=%h", nm, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset      = v.rst;
    if_req     = v.ifr;
    if_addr    = v.ia;
    if_flush   = v.fl;
    d_req      = v.dr;
    d_we       = v.we;
    d_funct3   = v.f3;
    d_addr     = v.da;
    d_wdata    = v.wd;
    prog_we_en = v.pe;
    mem_rdata  = v.mr;
    reg_rdata  = v.rr;
  endtask

  task automatic check_vec(input vec_t v, input int r);
    chk("if_gnt", r, 32'(if_gnt), 32'(v.ig));
    chk("if_rvalid", r, 32'(if_rvalid), 32'(v.iv));
    chk("if_rdata", r, if_rdata, v.ird);
    chk("if_err", r, 32'(if_err), 32'(v.ie));
    chk("d_gnt", r, 32'(d_gnt), 32'(v.dg));
    chk("d_rvalid", r, 32'(d_rvalid), 32'(v.dv));
    chk("d_rdata", r, d_rdata, v.drd);
    chk("d_err", r, 32'(d_err), 32'(v.de));
    chk("mem_req", r, 32'(mem_req), 32'(v.mq));
    chk("mem_we", r, 32'(mem_we), 32'(v.mw));
    chk("mem_funct3", r, 32'(mem_funct3), 32'(v.mf));
    chk("mem_addr", r, mem_addr, v.ma);
    chk("mem_wdata", r, mem_wdata, v.mwd);
    chk("prog_writing", r, 32'(prog_writing), 32'(v.pw));
    chk("reg_write", r, 32'(reg_write), 32'(v.rw));
    chk("reg_addr", r, 32'(reg_addr), 32'(v.ra));
    chk("reg_wdata", r, reg_wdata, v.rwd);
  endtask

  function automatic vec_t fetch_row(input logic [31:0] a);
    vec_t v = '0;
    v.ifr = 1'b1; v.ia = a;
    v.ig = 1'b1; v.mq = 1'b1; v.mf = 3'b010; v.ma = a;
    return v;
  endfunction

  function automatic vec_t both_row(input logic [31:0] mr);
    vec_t v = '0;
    v.ifr = 1'b1; v.ia = 32'h400;
    v.dr = 1'b1; v.f3 = 3'b010; v.da = 32'h2000;
    v.mr = mr;
    v.dg = 1'b1; v.mq = 1'b1; v.mf = 3'b010; v.ma = 32'h2000;
    return v;
  endfunction

  task automatic build_table();
    vec_t v;
    // reset ignores held requests
    v = '0; v.rst = 1; v.ifr = 1; v.ia = 32'h100;
    v.dr = 1; v.da = 32'h2000; vq.push_back(v);
    vq.push_back(v);
    // single fetch, data one cycle later
    vq.push_back(fetch_row(32'h100));
    v = '0; v.mr = 32'h13; v.iv = 1; v.ird = 32'h13; vq.push_back(v);
    // four back-to-back fetches
    vq.push_back(fetch_row(32'h104));
    v = fetch_row(32'h108); v.mr = 32'hA1; v.iv = 1; v.ird = 32'hA1;
    vq.push_back(v);
    v = fetch_row(32'h10C); v.mr = 32'hA2; v.iv = 1; v.ird = 32'hA2;
    vq.push_back(v);
    v = fetch_row(32'h110); v.mr = 32'hA3; v.iv = 1; v.ird = 32'hA3;
    vq.push_back(v);
    v = '0; v.mr = 32'hA4; v.iv = 1; v.ird = 32'hA4; vq.push_back(v);
    // contention: 4 data grants, then forced fetch, then data again
    vq.push_back(both_row(32'h0));
    for (int k = 1; k <= 3; k++) begin
      v = both_row(32'hD0 + k); v.dv = 1; v.drd = 32'hD0 + k;
      vq.push_back(v);
    end
    v = both_row(32'hD4); v.ia = 32'h200;
    v.dg = 0; v.ig = 1; v.ma = 32'h200; v.dv = 1; v.drd = 32'hD4;
    vq.push_back(v);
    v = both_row(32'h55); v.iv = 1; v.ird = 32'h55; vq.push_back(v);
    v = '0; v.mr = 32'hD5; v.dv = 1; v.drd = 32'hD5; vq.push_back(v);
    // register window load, value held across a changed reg_rdata
    v = '0; v.dr = 1; v.da = 32'h4010; v.f3 = 3'b010; v.rr = 32'hCAFE;
    v.dg = 1; v.ra = 15'h4010; vq.push_back(v);
    v = '0; v.mr = 32'h99; v.dv = 1; v.drd = 32'hCAFE; vq.push_back(v);
    // register window store
    v = '0; v.dr = 1; v.we = 1; v.da = 32'h4004; v.wd = 32'h12345678;
    v.dg = 1; v.rw = 1; v.ra = 15'h4004; v.rwd = 32'h12345678;
    vq.push_back(v);
    v = '0; v.mr = 32'h77; v.dv = 1; vq.push_back(v);
    // blocked program store
    v = '0; v.dr = 1; v.we = 1; v.da = 32'h40; v.wd = 32'hDEAD;
    v.f3 = 3'b010; v.dg = 1; vq.push_back(v);
    v = '0; v.mr = 32'h77; v.dv = 1; v.de = 1; vq.push_back(v);
    // permitted program store
    v = '0; v.dr = 1; v.we = 1; v.da = 32'h40; v.wd = 32'hBEEF;
    v.f3 = 3'b010; v.pe = 1; v.dg = 1; v.mq = 1; v.mw = 1;
    v.mf = 3'b010; v.ma = 32'h40; v.mwd = 32'hBEEF; v.pw = 1;
    vq.push_back(v);
    v = '0; v.mr = 32'h77; v.dv = 1; vq.push_back(v);
    // data region store with protection on: allowed, not a program write
    v = '0; v.dr = 1; v.we = 1; v.da = 32'h2004; v.wd = 32'h0F0F;
    v.f3 = 3'b001; v.dg = 1; v.mq = 1; v.mw = 1;
    v.mf = 3'b001; v.ma = 32'h2004; v.mwd = 32'h0F0F;
    vq.push_back(v);
    v = '0; v.mr = 32'h77; v.dv = 1; vq.push_back(v);
    // flush kills the in-flight fetch response
    vq.push_back(fetch_row(32'h300));
    v = '0; v.fl = 1; v.mr = 32'h33; vq.push_back(v);
    // flush with nothing in flight has no effect
    v = fetch_row(32'h304); v.fl = 1; vq.push_back(v);
    v = '0; v.mr = 32'h44; v.iv = 1; v.ird = 32'h44; vq.push_back(v);
    // fetch from register window
    v = '0; v.ifr = 1; v.ia = 32'h4000; v.ig = 1; vq.push_back(v);
    v = '0; v.mr = 32'h66; v.iv = 1; v.ie = 1; vq.push_back(v);
    // build up wait count, reset mid-operation
    vq.push_back(both_row(32'h0));
    v = both_row(32'hE1); v.dv = 1; v.drd = 32'hE1; vq.push_back(v);
    v = both_row(32'hE2); v.dv = 1; v.drd = 32'hE2; vq.push_back(v);
    v = both_row(32'hE3); v.rst = 1;
    v.dg = 0; v.mq = 0; v.mf = 0; v.ma = 0; vq.push_back(v);
    vq.push_back(both_row(32'hE4));
    for (int k = 5; k <= 7; k++) begin
      v = both_row(32'hE0 + k); v.dv = 1; v.drd = 32'hE0 + k;
      vq.push_back(v);
    end
    v = both_row(32'hE8); v.dg = 0; v.ig = 1; v.ma = 32'h400;
    v.dv = 1; v.drd = 32'hE8; vq.push_back(v);
    v = '0; v.mr = 32'h4B; v.iv = 1; v.ird = 32'h4B; vq.push_back(v);
  endtask

  initial begin
    vec_t v;
    build_table();
    for (int r = 0; r < vq.size(); r++) begin
      @(negedge clk);
      apply(vq[r]);
      #1;
      check_vec(vq[r], r);
      chk("one_grant", r, 32'(if_gnt && d_gnt), 32'd0);
      chk("one_rvalid", r, 32'(if_rvalid && d_rvalid), 32'd0);
    end
    // data load followed by if_flush: data response must survive
    @(negedge clk);
    v = '0; v.dr = 1; v.da = 32'h2008; v.f3 = 3'b100;
    apply(v);
    #1;
    chk("seq_load_gnt", 100, 32'(d_gnt), 32'd1);
    chk("seq_load_f3", 100, 32'(mem_funct3), 32'd4);
    @(negedge clk);
    v = '0; v.fl = 1; v.mr = 32'h5A;
    apply(v);
    #1;
    chk("seq_flush_dv", 101, 32'(d_rvalid), 32'd1);
    chk("seq_flush_drd", 101, d_rdata, 32'h5A);
    chk("seq_flush_iv", 101, 32'(if_rvalid), 32'd0);
    @(negedge clk);
    apply('0);
    #1;
    chk("seq_idle_dv", 102, 32'(d_rvalid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
